// File: rtl/aes_pkg.sv
// Shared AES constants and types: S-box, round constants, key-size helpers, FSM state.
package aes_pkg;

  localparam int unsigned Nb = 4;

  // Entry 0 is the leftmost byte so SBOX[x] reads like the FIPS-197 table.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon[1..10]; index 0 and out-of-range indices are never used by the schedule.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Returns 0 for unsupported key lengths so any Nr then fails the check.
  function automatic int unsigned nr_for_nk(input int unsigned nk);
    if (nk == 4 || nk == 6 || nk == 8) return nk + 6;
    return 0;
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, pure combinational byte lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/key_expansion.sv
// Iterative AES key schedule: one 32-bit schedule word per clock after a start pulse.
module key_expansion
  import aes_pkg::*;
#(
  parameter int unsigned Nk = 4,
  parameter int unsigned Nr = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [32*Nk-1:0]          key,
  output logic                      busy,
  output logic                      done,
  output logic [32*(4*Nr+4)-1:0]    w
);

  localparam int unsigned NumWords = Nb * (Nr + 1);
  localparam int unsigned IdxW     = $clog2(NumWords);
  localparam int unsigned SubW     = $clog2(Nk + 1);

  if (Nr != nr_for_nk(Nk)) begin : g_param_check
    $error("key_expansion: Nr must equal Nk + 6 with Nk in {4, 6, 8}");
  end

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q;
  logic [SubW-1:0] sub_q;   // i mod Nk
  logic [3:0]      rc_q;    // i / Nk
  logic [31:0]     w_q [NumWords];

  logic [31:0] prev_word, back_word, rot_word, sub_in, sub_out, temp, new_word;
  logic        last_word, load;

  assign load      = start && (state_q != StRun);
  assign last_word = (idx_q == IdxW'(NumWords - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StRun;
      StRun:          if (last_word) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  // Select w[i-1] and w[i-Nk] without out-of-range indexing.
  always_comb begin
    prev_word = '0;
    back_word = '0;
    for (int k = 0; k < NumWords; k++) begin
      if (IdxW'(k) == idx_q - IdxW'(1))  prev_word = w_q[k];
      if (IdxW'(k) == idx_q - IdxW'(Nk)) back_word = w_q[k];
    end
  end

  assign rot_word = {prev_word[23:0], prev_word[31:24]};
  assign sub_in   = (sub_q == '0) ? rot_word : prev_word;

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .a (sub_in[8*b +: 8]),
      .y (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = prev_word;
    if (sub_q == '0)                         temp = sub_out ^ {rcon(rc_q), 24'h0};
    else if ((Nk > 6) && (sub_q == SubW'(4))) temp = sub_out;
    new_word = back_word ^ temp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NumWords; k++) w_q[k] <= '0;
      idx_q <= '0;
      sub_q <= '0;
      rc_q  <= '0;
    end else if (load) begin
      // Upper words keep their old contents until overwritten.
      for (int k = 0; k < Nk; k++) w_q[k] <= key[32*(Nk-1-k) +: 32];
      idx_q <= IdxW'(Nk);
      sub_q <= '0;
      rc_q  <= 4'd1;
    end else if (state_q == StRun) begin
      w_q[idx_q] <= new_word;
      idx_q      <= idx_q + IdxW'(1);
      if (sub_q == SubW'(Nk - 1)) begin
        sub_q <= '0;
        rc_q  <= rc_q + 4'd1;
      end else begin
        sub_q <= sub_q + SubW'(1);
      end
    end
  end

  for (genvar k = 0; k < NumWords; k++) begin : g_flatten
    assign w[32*(NumWords-1-k) +: 32] = w_q[k];
  end

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: AES-128 and AES-256 instances against FIPS-197 vectors.
module tb_key_expansion;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start128, start256;
  logic [127:0]   key128;
  logic [255:0]   key256;
  logic           busy128, done128, busy256, done256;
  logic [1407:0]  w128;
  logic [1919:0]  w256;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] Key1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1R1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K1R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K0R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] K0R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  key_expansion #(.Nk(4), .Nr(10)) dut128 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start128),
    .key   (key128),
    .busy  (busy128),
    .done  (done128),
    .w     (w128)
  );

  key_expansion #(.Nk(8), .Nr(14)) dut256 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start256),
    .key   (key256),
    .busy  (busy256),
    .done  (done256),
    .w     (w256)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rk128(input int r);
    return w128[1407 - 128*r -: 128];
  endfunction

  function automatic logic [31:0] wd256(input int k);
    return w256[1919 - 32*k -: 32];
  endfunction

  // Called just after a rising edge; consumes one edge (the start cycle).
  task automatic pulse(input bit sel, input logic [255:0] k);
    if (sel) begin key256 = k; start256 = 1'b1; end
    else     begin key128 = k[127:0]; start128 = 1'b1; end
    @(posedge clk); #1;
    start128 = 1'b0;
    start256 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int cycles);
    cycles = 0;
    while (!(sel ? done256 : done128) && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; start128 = 1'b0; start256 = 1'b0; key128 = '0; key256 = '0;
    #3;
    check("rst_busy", 128'(busy128), 128'd0);
    check("rst_done", 128'(done128), 128'd0);
    check("rst_w", 128'(|w128), 128'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // AES-128 reference key
    pulse(1'b0, 256'(Key1));
    check("start_busy", 128'(busy128), 128'd1);
    wait_done(1'b0, n);
    check("k1_latency", 128'(n), 128'd40);
    check("k1_round0", rk128(0), Key1);
    check("k1_round1", rk128(1), K1R1);
    check("k1_round10", rk128(10), K1R10);

    // Restart from DONE with all-zero key
    pulse(1'b0, 256'd0);
    check("restart_done_clr", 128'(done128), 128'd0);
    wait_done(1'b0, n);
    check("k0_latency", 128'(n), 128'd40);
    check("k0_round1", rk128(1), K0R1);
    check("k0_round10", rk128(10), K0R10);

    // Second start mid-RUN with a different key is ignored
    pulse(1'b0, 256'(Key1));
    repeat (10) begin @(posedge clk); #1; end
    pulse(1'b0, 256'd0);
    wait_done(1'b0, n);
    check("midrun_latency", 128'(n + 11), 128'd40);
    check("midrun_round1", rk128(1), K1R1);
    check("midrun_round10", rk128(10), K1R10);

    // Key toggling after done has no effect
    for (int c = 0; c < 10; c++) begin
      key128 = {4{$urandom}};
      @(posedge clk); #1;
    end
    check("hold_done", 128'(done128), 128'd1);
    check("hold_round0", rk128(0), Key1);
    check("hold_round10", rk128(10), K1R10);

    // Asynchronous reset mid-expansion
    pulse(1'b0, 256'(Key1));
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_w", 128'(|w128), 128'd0);
    check("arst_busy", 128'(busy128), 128'd0);
    check("arst_done", 128'(done128), 128'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pulse(1'b0, 256'(Key1));
    wait_done(1'b0, n);
    check("after_rst_latency", 128'(n), 128'd40);
    check("after_rst_round10", rk128(10), K1R10);

    // AES-256
    pulse(1'b1, Key256);
    wait_done(1'b1, n);
    check("k256_latency", 128'(n), 128'd52);
    check("k256_round0", w256[1919 -: 128], Key256[255 -: 128]);
    check("k256_w8", 128'(wd256(8)), 128'h9ba35411);
    check("k256_w9", 128'(wd256(9)), 128'h8e6925af);
    check("k256_w10", 128'(wd256(10)), 128'ha51a8b5f);
    check("k256_w11", 128'(wd256(11)), 128'h2067fcde);
    check("k256_w12", 128'(wd256(12)), 128'ha8b09c1a);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
